// File: rtl/mont_digit_sequencer_if.sv
// mont_digit_sequencer_if: handshake bundle between the radix-4 Montgomery sequencer, its host and the datapath
interface mont_digit_sequencer_if #(
    parameter int N = 1024
);
    localparam int CW = $clog2(N / 2);

    logic          start;
    logic [N-1:0]  in_A;
    logic [1:0]    m_lsb;
    logic          acc_valid;
    logic [1:0]    acc_lsb;
    logic [2:0]    select;
    logic          sel_valid;
    logic          shift_en;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] iter;

    modport master (
        output start, in_A, m_lsb, acc_valid, acc_lsb,
        input  select, sel_valid, shift_en, busy, done, err, iter
    );

    modport slave (
        input  start, in_A, m_lsb, acc_valid, acc_lsb,
        output select, sel_valid, shift_en, busy, done, err, iter
    );
endinterface

// File: rtl/mont_digit_sequencer.sv
// mont_digit_sequencer: scans A two bits per iteration and issues B/M addend select codes for radix-4 Montgomery
module mont_digit_sequencer #(
    parameter int N = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    mont_digit_sequencer_if.slave   bus
);
    localparam int DIGITS = N / 2;
    localparam int CW     = $clog2(N / 2);

    typedef enum logic [2:0] {IDLE, ISSUE_B, WAIT_B, ISSUE_M, WAIT_M, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [1:0]    q_q, q_d;
    logic [2:0]    select_q, select_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [CW-1:0] iter_q, iter_d;
    logic [1:0]    m_inv;
    logic [1:0]    q_new;

    // An odd M is its own inverse mod 4, so m' = -M mod 4
    assign m_inv = -bus.m_lsb;
    assign q_new = 2'(bus.acc_lsb * m_inv);

    // Next-state, operand shift, quotient capture and the registered select code
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        select_d = select_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        iter_d   = iter_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d  = ISSUE_B;
                a_d      = bus.in_A;
                iter_d   = '0;
                err_d    = 1'b0;
                busy_d   = 1'b1;
                select_d = {1'b0, bus.in_A[1:0]};
            end
            ISSUE_B: state_d = WAIT_B;
            WAIT_B: if (bus.acc_valid) begin
                state_d  = ISSUE_M;
                q_d      = q_new;
                select_d = (q_new == 2'd0) ? 3'b000 : {1'b1, q_new - 2'd1};
            end
            ISSUE_M: state_d = WAIT_M;
            WAIT_M: if (bus.acc_valid) begin
                err_d = err_q | (bus.acc_lsb != 2'b00);
                a_d   = a_q >> 2;
                if (iter_q == CW'(DIGITS - 1)) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    select_d = 3'b000;
                end else begin
                    state_d  = ISSUE_B;
                    iter_d   = iter_q + 1'b1;
                    select_d = {1'b0, a_d[1:0]};
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset, also clearing on mid-operation reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            q_q      <= 2'b00;
            select_q <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            iter_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            q_q      <= q_d;
            select_q <= select_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            iter_q   <= iter_d;
        end
    end

    assign bus.select    = select_q;
    assign bus.sel_valid = (state_q == ISSUE_B) || (state_q == ISSUE_M);
    assign bus.shift_en  = (state_q == ISSUE_M);
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.iter      = iter_q;
endmodule

// File: tb/tb_mont_digit_sequencer.sv
// tb_mont_digit_sequencer: randomized bench with a transaction-level reference model of the sequencer
module tb_mont_digit_sequencer;
    localparam int N      = 8;
    localparam int DIGITS = N / 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mont_digit_sequencer_if #(.N(N)) bus ();
    mont_digit_sequencer #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    logic [2:0] log_q[$];
    logic [2:0] mtbl [4] = '{3'd0, 3'd4, 3'd5, 3'd6};

    bit         m_active, m_issue, m_wait, m_done, m_err;
    int         m_k, m_iter;
    logic [2:0] m_sel;
    logic [N-1:0] m_a;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at cycle %0d", n, act, exp, cyc);
        end
    endtask

    // m' solves M*m' = -1 (mod 4)
    function automatic int minv(input int m);
        for (int x = 0; x < 4; x++) if ((m * x) % 4 == 3) return x;
        return 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: a list of 2*DIGITS adds per operation, each issued once and retired by acc_valid
    always @(posedge clk) begin : model
        bit act, iss, wt, dn, er;
        int k, it;
        logic [2:0] s;
        logic [N-1:0] av;
        act = m_active; iss = 0; wt = m_wait; dn = 0; er = m_err;
        k = m_k; it = m_iter; s = m_sel; av = m_a;
        if (reset) begin
            act = 0; wt = 0; er = 0; k = 0; it = 0; s = 0; av = 0;
        end else begin
            if (!m_active && !m_done && bus.start) begin
                act = 1; av = bus.in_A; k = 0; it = 0; er = 0;
                s = 3'(bus.in_A % 4); iss = 1;
            end else if (m_active && m_wait && bus.acc_valid) begin
                wt = 0;
                if (k % 2 == 0) begin
                    s = mtbl[(int'(bus.acc_lsb) * minv(int'(bus.m_lsb))) % 4];
                    k++; iss = 1;
                end else begin
                    er = er | (bus.acc_lsb != 2'b00);
                    if (k == 2 * DIGITS - 1) begin
                        act = 0; dn = 1; s = 0;
                    end else begin
                        k++; it++;
                        s = 3'((av >> (2 * it)) % 4);
                        iss = 1;
                    end
                end
            end
            if (m_issue) wt = 1;
        end
        m_active <= act; m_issue <= iss; m_wait <= wt; m_done <= dn; m_err <= er;
        m_k <= k; m_iter <= it; m_sel <= s; m_a <= av;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("select", bus.select, m_sel);
            chk("sel_valid", bus.sel_valid, m_issue);
            chk("shift_en", bus.shift_en, m_issue && (m_k % 2 == 1));
            chk("busy", bus.busy, m_active);
            chk("done", bus.done, m_done);
            chk("err", bus.err, m_err);
            chk("iter", bus.iter, m_iter);
        end
        if (bus.sel_valid === 1'b1) log_q.push_back(bus.select);
    end

    // One operation; bl/mv hold per-iteration acc_lsb for the B and M phases, dly<0 means random latency
    task automatic run_op(input logic [N-1:0] a, input logic [1:0] ml, input logic [7:0] bl,
                          input logic [7:0] mv, input int dly, input int abort_ph, input bit poke,
                          output int span, output logic b1);
        int t0, d;
        bit ok;
        span = 0; b1 = 1'b0;
        @(posedge clk);
        #1 bus.in_A = a; bus.m_lsb = ml; bus.start = 1'b1; t0 = cyc;
        log_q.delete();
        @(posedge clk);
        #1 bus.start = 1'b0; bus.in_A = N'($urandom);
        for (int ph = 0; ph < 2 * DIGITS; ph++) begin
            ok = 0;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (ph == 0 && w == 0) b1 = bus.busy;
                if (bus.sel_valid) begin ok = 1; break; end
            end
            if (!ok) begin chk("sel_valid_timeout", 0, 1); return; end
            @(posedge clk);
            if (ph == abort_ph) begin
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
            d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            repeat (d) @(posedge clk);
            #1 bus.acc_valid = 1'b1;
            bus.acc_lsb = (ph % 2 == 0) ? bl[2 * (ph / 2) +: 2] : mv[2 * (ph / 2) +: 2];
            if (poke && ph == 0) bus.start = 1'b1;
            @(posedge clk);
            #1 bus.acc_valid = 1'b0; bus.acc_lsb = 2'($urandom); bus.start = 1'b0;
        end
        ok = 0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bus.done) begin ok = 1; break; end
        end
        if (!ok) chk("done_timeout", 0, 1);
        else span = cyc - t0 + 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int span;
        logic b1;
        logic [2:0] exp1 [8] = '{3'd0, 3'd4, 3'd1, 3'd4, 3'd3, 3'd4, 3'd2, 3'd4};
        bus.start = 1'b0; bus.in_A = '0; bus.m_lsb = 2'b11; bus.acc_valid = 1'b0; bus.acc_lsb = 2'b00;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("reset_select", bus.select, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_iter", bus.iter, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_op(8'hB4, 2'b11, 8'h55, 8'h00, 0, -1, 0, span, b1);
        for (int i = 0; i < 8; i++) chk("t1_code", log_q[i], exp1[i]);
        chk("t1_count", log_q.size(), 8);
        chk("t1_span", span, 18);
        chk("t1_err", bus.err, 0);

        run_op(8'h00, 2'b01, 8'h39, 8'h00, 0, -1, 0, span, b1);
        chk("t2_q3", log_q[1], 6);
        chk("t2_q2", log_q[3], 5);
        chk("t2_q1", log_q[5], 4);
        chk("t2_q0", log_q[7], 0);

        run_op(8'h6C, 2'b11, 8'hA7, 8'h00, 5, -1, 0, span, b1);
        chk("t3_pulses", log_q.size(), 8);
        chk("t3_span", span, 58);

        run_op(8'h1E, 2'b01, 8'h1B, 8'h08, -1, -1, 0, span, b1);
        chk("t4_err_set", bus.err, 1);
        @(negedge clk);
        chk("t4_err_held", bus.err, 1);
        run_op(8'hE1, 2'b01, 8'hC6, 8'h00, -1, -1, 0, span, b1);
        chk("t4_err_clean", bus.err, 0);

        run_op(8'h93, 2'b11, 8'h2D, 8'h00, 0, 5, 0, span, b1);
        @(negedge clk);
        chk("t5_select", bus.select, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_iter", bus.iter, 0);
        @(posedge clk);
        #1 bus.acc_valid = 1'b1; bus.acc_lsb = 2'b10;
        repeat (2) @(posedge clk);
        #1 bus.acc_valid = 1'b0;
        chk("t5_stray", bus.busy, 0);
        run_op(8'h5A, 2'b11, 8'hF0, 8'h00, -1, -1, 1, span, b1);
        chk("t5_pulses", log_q.size(), 8);

        run_op(8'hC3, 2'b01, 8'h4E, 8'h00, 0, -1, 0, span, b1);
        chk("t6_busy", b1, 1);
        chk("t6_span", span, 18);

        for (int r = 0; r < 12; r++) begin
            logic [7:0] mv;
            mv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            run_op(N'($urandom), ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01, 8'($urandom), mv,
                   -1, -1, 1'($urandom), span, b1);
            chk("rand_pulses", log_q.size(), 8);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
